// File: rtl/dro_readout_sched_pkg.sv
// Shared definitions for the DRO readout scheduler: FSM state encoding and
// the setup-counter width helper.
package dro_readout_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Bits needed to hold a counter that saturates at t_setup.
    function automatic int cnt_width(input int t_setup);
        return $clog2(t_setup + 1);
    endfunction

endpackage

// File: rtl/dro_readout_sched_rr_pick.sv
// Combinational round-robin picker: grants the first requester after ptr,
// wrapping modulo N.
module dro_readout_sched_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    // Scan ptr+1, ptr+2, ... and keep the first hit.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx] && !found) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end else begin
                found = found;
            end
        end
        any = found;
    end

endmodule

// File: rtl/dro_readout_sched.sv
// Readout clock scheduler for a bank of DRO cells sharing one output line:
// one clocked cell per slot, enforced gap between slots, setup hold-off.
module dro_readout_sched
    import dro_readout_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int T_SETUP = 3,
    parameter int T_GAP   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] d_pulse,
    input  logic [N_CH-1:0] rd_req,
    output logic [N_CH-1:0] dro_clk,
    output logic [N_CH-1:0] pending,
    output logic            busy,
    output logic [N_CH-1:0] hold_viol
);

    localparam int            CW       = cnt_width(T_SETUP);
    localparam int            PW       = $clog2(N_CH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(T_SETUP);
    localparam logic [3:0]    GAP_INIT = (T_GAP == 0) ? 4'd0 : 4'(T_GAP - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [3:0]      gap_q, gap_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] dro_clk_q, dro_clk_d;
    logic [N_CH-1:0] hold_viol_q, hold_viol_d;
    logic [N_CH-1:0] ready_s, elig_s, grant_s, pick_oh_s;
    logic [PW-1:0]   pick_idx_s;
    logic            pick_any_s;

    // Readiness from registered setup counters only.
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            ready_s[i] = (cnt_q[i] == CNT_MAX);
        end
    end

    assign elig_s = pending_q & ready_s;

    dro_readout_sched_rr_pick #(.N(N_CH), .PW(PW)) u_pick (
        .req       (elig_s),
        .ptr       (ptr_q),
        .grant     (pick_oh_s),
        .grant_idx (pick_idx_s),
        .any       (pick_any_s)
    );

    // Slot FSM: arbitrate in IDLE, one FIRE cycle, then T_GAP dead cycles.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        dro_clk_d = '0;
        grant_s   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d   = ST_FIRE;
                    dro_clk_d = pick_oh_s;
                    grant_s   = pick_oh_s;
                    ptr_d     = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRE: begin
                if (T_GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GAP_INIT;
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A fresh request beats a same-cycle grant clear.
    assign pending_d   = (pending_q & ~grant_s) | rd_req;
    assign hold_viol_d = d_pulse & dro_clk_q;

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PW'(N_CH - 1);
            gap_q       <= 4'd0;
            pending_q   <= '0;
            dro_clk_q   <= '0;
            hold_viol_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gap_q       <= gap_d;
            pending_q   <= pending_d;
            dro_clk_q   <= dro_clk_d;
            hold_viol_q <= hold_viol_d;
        end
    end

    // Per-channel setup counters, saturating so channels start ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= CNT_MAX;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (d_pulse[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != CNT_MAX) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else begin
                    cnt_q[i] <= cnt_q[i];
                end
            end
        end
    end

    assign dro_clk   = dro_clk_q;
    assign pending   = pending_q;
    assign hold_viol = hold_viol_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dro_readout_sched.sv
// Directed bench for dro_readout_sched with N_CH=4, T_SETUP=3, T_GAP=2.
module tb_dro_readout_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] d_pulse;
    logic [3:0] rd_req;
    logic [3:0] dro_clk;
    logic [3:0] pending;
    logic       busy;
    logic [3:0] hold_viol;
    int         checks;
    int         errors;

    dro_readout_sched #(.N_CH(4), .T_SETUP(3), .T_GAP(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_pulse   (d_pulse),
        .rd_req    (rd_req),
        .dro_clk   (dro_clk),
        .pending   (pending),
        .busy      (busy),
        .hold_viol (hold_viol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        d_pulse = 4'b0000;
        rd_req  = 4'b0000;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        d_pulse = 4'b0000;
        rd_req  = 4'b1111;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dro_clk, pending, hold_viol, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {dro_clk, pending, hold_viol, busy});
        end
        rd_req = 4'b0000;
        rst_n  = 1'b1;
        step();
        checks++;
        if ({dro_clk, pending, busy} !== 9'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b required 0", {dro_clk, pending, busy});
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_busy;
        do_reset();
        rd_req = 4'b0100;
        step();
        rd_req = 4'b0000;
        checks++;
        if (pending !== 4'b0100 || dro_clk !== 4'b0000) begin
            errors++;
            $display("FAIL single_pending: pending %b dro_clk %b required 0100 0000", pending, dro_clk);
        end
        step();
        checks++;
        if (dro_clk !== 4'b0100 || pending !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_fire: dro_clk %b pending %b busy %b required 0100 0000 1", dro_clk, pending, busy);
        end
        exp_busy = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (busy !== exp_busy[k] || dro_clk !== 4'b0000) begin
                errors++;
                $display("FAIL single_busy%0d: busy %b dro_clk %b required %b 0000", k, busy, dro_clk, exp_busy[k]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        do_reset();
        rd_req = 4'b1111;
        step();
        rd_req = 4'b0000;
        for (int g = 0; g < 4; g++) begin
            exp = 4'b0001 << g;
            step();
            checks++;
            if (dro_clk !== exp) begin
                errors++;
                $display("FAIL fair_grant%0d: got %b required %b", g, dro_clk, exp);
            end
            if (g < 3) begin
                for (int k = 0; k < 3; k++) begin
                    step();
                    checks++;
                    if (dro_clk !== 4'b0000) begin
                        errors++;
                        $display("FAIL fair_gap%0d_%0d: got %b required 0000", g, k, dro_clk);
                    end
                end
            end
        end
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL fair_drained: got %b required 0000", pending);
        end
    endtask

    task automatic test_setup_holdoff();
        do_reset();
        d_pulse = 4'b0010;
        rd_req  = 4'b0010;
        step();
        d_pulse = 4'b0000;
        rd_req  = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dro_clk !== 4'b0000 || pending !== 4'b0010) begin
                errors++;
                $display("FAIL holdoff_wait%0d: dro_clk %b pending %b required 0000 0010", k, dro_clk, pending);
            end
        end
        step();
        checks++;
        if (dro_clk !== 4'b0010) begin
            errors++;
            $display("FAIL holdoff_fire: got %b required 0010", dro_clk);
        end
    endtask

    task automatic test_skip_not_ready();
        do_reset();
        rd_req  = 4'b0011;
        d_pulse = 4'b0001;
        step();
        rd_req  = 4'b0000;
        d_pulse = 4'b0000;
        step();
        checks++;
        if (dro_clk !== 4'b0010 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL skip_first: dro_clk %b pending %b required 0010 0001", dro_clk, pending);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dro_clk !== 4'b0000) begin
                errors++;
                $display("FAIL skip_gap%0d: got %b required 0000", k, dro_clk);
            end
        end
        step();
        checks++;
        if (dro_clk !== 4'b0001) begin
            errors++;
            $display("FAIL skip_second: got %b required 0001", dro_clk);
        end
    endtask

    task automatic test_hold_viol();
        do_reset();
        rd_req = 4'b1000;
        step();
        rd_req = 4'b0000;
        step();
        d_pulse = 4'b1000;
        checks++;
        if (dro_clk !== 4'b1000 || hold_viol !== 4'b0000) begin
            errors++;
            $display("FAIL hv_fire: dro_clk %b hold_viol %b required 1000 0000", dro_clk, hold_viol);
        end
        step();
        d_pulse = 4'b0000;
        checks++;
        if (hold_viol !== 4'b1000) begin
            errors++;
            $display("FAIL hv_flag: got %b required 1000", hold_viol);
        end
        rd_req = 4'b1000;
        step();
        rd_req = 4'b0000;
        checks++;
        if (hold_viol !== 4'b0000) begin
            errors++;
            $display("FAIL hv_single: got %b required 0000", hold_viol);
        end
        // Counter was cleared by the violating pulse, so ch3 waits until cnt saturates.
        step();
        step();
        checks++;
        if (dro_clk !== 4'b0000) begin
            errors++;
            $display("FAIL hv_cnt_wait: got %b required 0000", dro_clk);
        end
        step();
        checks++;
        if (dro_clk !== 4'b1000) begin
            errors++;
            $display("FAIL hv_cnt_fire: got %b required 1000", dro_clk);
        end
    endtask

    task automatic test_reset_mid_gap();
        do_reset();
        rd_req = 4'b0001;
        step();
        rd_req = 4'b0100;
        step();
        rd_req = 4'b0000;
        step();
        checks++;
        if (busy !== 1'b1 || pending !== 4'b0100) begin
            errors++;
            $display("FAIL midgap_pre: busy %b pending %b required 1 0100", busy, pending);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pending !== 4'b0000 || dro_clk !== 4'b0000) begin
            errors++;
            $display("FAIL midgap_async: busy %b pending %b dro_clk %b required 0 0000 0000", busy, pending, dro_clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_req = 4'b0011;
        step();
        rd_req = 4'b0000;
        step();
        checks++;
        if (dro_clk !== 4'b0001) begin
            errors++;
            $display("FAIL midgap_ch0_first: got %b required 0001", dro_clk);
        end
        repeat (3) step();
        step();
        checks++;
        if (dro_clk !== 4'b0010) begin
            errors++;
            $display("FAIL midgap_ch1_next: got %b required 0010", dro_clk);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        d_pulse = 4'b0000;
        rd_req  = 4'b0000;
        test_reset();
        test_single();
        test_fairness();
        test_setup_holdoff();
        test_skip_not_ready();
        test_hold_viol();
        test_reset_mid_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
